// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, width default.
package mdu_iter_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  // op[0]=0 selects the signed variants (MULT, DIV)
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// EX-stage <-> MDU signal bundle; master is the pipeline side, slave is the MDU.
interface mdu_iter_if #(parameter int unsigned WIDTH = 32);
  logic             startE;
  logic [1:0]       opE;
  logic [WIDTH-1:0] srcaE;
  logic [WIDTH-1:0] srcbE;
  logic             mthiE;
  logic             mtloE;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busyE;
  logic             doneE;

  modport master (
    output startE, opE, srcaE, srcbE, mthiE, mtloE,
    input  hi, lo, busyE, doneE
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, mthiE, mtloE,
    output hi, lo, busyE, doneE
  );
endinterface

// File: rtl/mdu_iter_datapath.sv
// Magnitude shift-add / restoring-divide datapath with iteration counter and final sign fix.
module mdu_datapath
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_srca,
  input  logic [WIDTH-1:0] i_srcb,
  input  logic             i_step,
  output logic             o_last,
  output logic [WIDTH-1:0] o_fix_hi_c,
  output logic [WIDTH-1:0] o_fix_lo_c
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;

  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;

  // r_acc holds {partial product, multiplier} for MUL and {remainder, quotient/dividend} for DIV
  always_comb begin
    w_sa       = is_signed_op(i_op) & i_srca[WIDTH-1];
    w_sb       = is_signed_op(i_op) & i_srcb[WIDTH-1];
    w_abs_a    = w_sa ? WIDTH'(-i_srca) : i_srca;
    w_abs_b    = w_sb ? WIDTH'(-i_srcb) : i_srcb;
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff     = {1'b0, w_shift} - {2'b00, r_b};
    w_div_next = w_diff[WIDTH+1] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_div   <= i_op[1];
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      r_b     <= w_abs_b;
      r_acc   <= {WIDTH'(0), w_abs_a};
      r_cnt   <= '0;
    end else if (i_step) begin
      r_acc   <= r_div ? w_div_next : w_mul_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Signed results: product/quotient negated on sign mismatch, remainder follows the dividend
  always_comb begin
    w_prod     = r_neg_q ? (2*WIDTH)'(-r_acc) : r_acc;
    o_fix_hi_c = w_prod[2*WIDTH-1:WIDTH];
    o_fix_lo_c = w_prod[WIDTH-1:0];
    if (r_div) begin
      o_fix_lo_c = r_neg_q ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      o_fix_hi_c = r_neg_r ? WIDTH'(-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    end
  end

  assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mdu_iter.sv
// EX-stage iterative MDU: FSM, busy/done generation and the architectural HI/LO registers.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic       clk,
  input  logic       resetn,
  mdu_iter_if.slave  bus
);
  mdu_state_e       r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_load;
  logic             w_step;
  logic             w_move_ok;
  logic             w_last;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_load    = (r_state == ST_IDLE) & bus.startE;
  assign w_step    = (r_state == ST_MUL) | (r_state == ST_DIV);
  assign w_move_ok = ((r_state == ST_IDLE) | (r_state == ST_DONE)) & ~bus.startE;

  mdu_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_load),
    .i_op       (bus.opE),
    .i_srca     (bus.srcaE),
    .i_srcb     (bus.srcbE),
    .i_step     (w_step),
    .o_last     (w_last),
    .o_fix_hi_c (w_fix_hi),
    .o_fix_lo_c (w_fix_lo)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FIX);
      // MTHI/MTLO only land between operations and lose to a simultaneous start
      if (w_move_ok) begin
        if (bus.mthiE) r_hi <= bus.srcaE;
        if (bus.mtloE) r_lo <= bus.srcaE;
      end
      case (r_state)
        ST_IDLE: if (bus.startE) r_state <= bus.opE[1] ? ST_DIV : ST_MUL;
        ST_MUL:  if (w_last) r_state <= ST_FIX;
        ST_DIV:  if (w_last) r_state <= ST_FIX;
        ST_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Busy drops in DONE so the mul/div leaves EX without retriggering
  assign bus.busyE = w_load | w_step | (r_state == ST_FIX);
  assign bus.doneE = r_done;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed test-plan vectors plus random traffic checked every cycle against a phase/arithmetic model.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus();
  mdu_iter #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Architectural result {HI, LO} of one mul/div instruction
  function automatic logic [63:0] mdu_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; return 64'(p); end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, (sa >= 0) ? 32'hFFFFFFFF : 32'd1};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: phase 0 idle, 1..W iterating, W+1 fix, W+2 done
  int          m_phase = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  bit          chk_en = 1'b0;
  logic        exp_busy;

  always @(posedge clk) begin
    if (!resetn) begin
      m_phase <= 0;
      m_hi    <= '0;
      m_lo    <= '0;
    end else if (m_phase == 0) begin
      if (bus.startE) begin
        m_pend  <= mdu_model(bus.opE, bus.srcaE, bus.srcbE);
        m_phase <= 1;
      end else begin
        if (bus.mthiE) m_hi <= bus.srcaE;
        if (bus.mtloE) m_lo <= bus.srcaE;
      end
    end else if (m_phase == W + 2) begin
      if (!bus.startE) begin
        if (bus.mthiE) m_hi <= bus.srcaE;
        if (bus.mtloE) m_lo <= bus.srcaE;
      end
      m_phase <= 0;
    end else if (m_phase == W + 1) begin
      m_hi    <= m_pend[63:32];
      m_lo    <= m_pend[31:0];
      m_phase <= m_phase + 1;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_busy = (m_phase == 0 && bus.startE) || (m_phase >= 1 && m_phase <= W + 1);
      check("busyE", bus.busyE, exp_busy);
      check("doneE", bus.doneE, m_phase == W + 2);
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  int busy_n, done_n;

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output int nb, output int nd);
    bit seen;
    seen = 1'b0;
    nb = 0;
    nd = 0;
    @(posedge clk); #1;
    bus.startE = 1'b1; bus.opE = op; bus.srcaE = a; bus.srcbE = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busyE) nb++;
      if (bus.doneE) begin nd++; seen = 1'b1; end
      @(posedge clk); #1;
      if (!hold || seen) bus.startE = 1'b0;
      bus.srcaE = $urandom;
      bus.srcbE = $urandom;
    end
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.doneE) begin ok = 1'b1; break; end
    end
    check(name, ok, 1'b1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.startE = 1'b0; bus.opE = 2'b00; bus.srcaE = '0; bus.srcbE = '0;
    bus.mthiE = 1'b0; bus.mtloE = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    check("reset_busy", bus.busyE, 1'b0);
    check("reset_done", bus.doneE, 1'b0);

    check("model_mult", mdu_model(MDU_MULT, 32'hFFFFFFFD, 32'd7), 64'hFFFFFFFF_FFFFFFEB);
    check("model_multu", mdu_model(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
    check("model_div", mdu_model(MDU_DIV, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    check("model_div_ovf", mdu_model(MDU_DIV, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    check("model_divu0", mdu_model(MDU_DIVU, 32'd100, 32'd0), 64'h00000064_FFFFFFFF);
    check("model_div0", mdu_model(MDU_DIV, 32'hFFFFFFF6, 32'd0), 64'hFFFFFFF6_00000001);

    run_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, 1'b0, busy_n, done_n);
    check("mult_busy_cycles", 64'(busy_n), 64'd34);
    check("mult_done_pulses", 64'(done_n), 64'd1);
    check("mult_hi", bus.hi, 32'hFFFFFFFF);
    check("mult_lo", bus.lo, 32'hFFFFFFEB);

    run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, busy_n, done_n);
    check("multu_busy_cycles", 64'(busy_n), 64'd34);
    check("multu_done_pulses", 64'(done_n), 64'd1);
    check("multu_hi", bus.hi, 32'hFFFFFFFE);
    check("multu_lo", bus.lo, 32'h00000001);
    @(negedge clk);
    check("multu_no_restart", bus.busyE, 1'b0);

    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, busy_n, done_n);
    check("div_hi", bus.hi, 32'hFFFFFFFF);
    check("div_lo", bus.lo, 32'hFFFFFFFD);
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, busy_n, done_n);
    check("div_ovf_hi", bus.hi, 32'd0);
    check("div_ovf_lo", bus.lo, 32'h80000000);
    run_op(MDU_DIVU, 32'd100, 32'd0, 1'b0, busy_n, done_n);
    check("divu0_hi", bus.hi, 32'h00000064);
    check("divu0_lo", bus.lo, 32'hFFFFFFFF);
    run_op(MDU_DIV, 32'hFFFFFFF6, 32'd0, 1'b0, busy_n, done_n);
    check("div0_hi", bus.hi, 32'hFFFFFFF6);
    check("div0_lo", bus.lo, 32'd1);

    @(posedge clk); #1 bus.srcaE = 32'h0000CAFE; bus.mtloE = 1'b1;
    @(posedge clk); #1 bus.mtloE = 1'b0;
    @(negedge clk);
    check("mtlo_lo", bus.lo, 32'h0000CAFE);

    @(posedge clk); #1
    bus.srcaE = 32'h1111; bus.srcbE = 32'd2; bus.opE = MDU_MULTU; bus.mthiE = 1'b1; bus.startE = 1'b1;
    @(posedge clk); #1 bus.mthiE = 1'b0; bus.startE = 1'b0;
    @(negedge clk);
    check("mthi_dropped_hi", bus.hi, 32'hFFFFFFF6);
    check("mthi_start_busy", bus.busyE, 1'b1);
    wait_done("mthi_start_done");
    check("mthi_start_hi", bus.hi, 32'd0);
    check("mthi_start_lo", bus.lo, 32'h2222);

    @(posedge clk); #1 bus.srcaE = 32'h12; bus.mthiE = 1'b1;
    @(posedge clk); #1 bus.mthiE = 1'b0; bus.srcaE = 32'h34; bus.mtloE = 1'b1;
    @(posedge clk); #1 bus.mtloE = 1'b0;
    bus.opE = MDU_DIVU; bus.srcaE = 32'd1000; bus.srcbE = 32'd7; bus.startE = 1'b1;
    @(posedge clk); #1 bus.startE = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("pre_reset_hi", bus.hi, 32'h12);
    check("pre_reset_lo", bus.lo, 32'h34);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busyE, 1'b0);
    check("abort_done", bus.doneE, 1'b0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);

    for (int i = 0; i < 2500; i++) begin
      @(posedge clk); #1;
      resetn     = ($urandom % 400) != 0;
      bus.startE = ($urandom % 4) == 0;
      bus.opE    = 2'($urandom);
      bus.srcaE  = rnd_operand();
      bus.srcbE  = rnd_operand();
      bus.mthiE  = ($urandom % 4) == 0;
      bus.mtloE  = ($urandom % 4) == 0;
    end
    @(posedge clk); #1;
    resetn = 1'b1; bus.startE = 1'b0; bus.mthiE = 1'b0; bus.mtloE = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
